// File: rtl/accu_pkg.sv
// Shared definitions for the accumulator front-end: debounce FSM state
// encodings (also shown on the LEDs) and the press counter width.
package accu_pkg;

    localparam int PRESS_CNT_W = 8;

    localparam logic [1:0] COND_IDLE         = 2'd0;
    localparam logic [1:0] COND_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] COND_HELD         = 2'd2;
    localparam logic [1:0] COND_RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// The output clears to 0 while reset is asserted.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments, so q takes the old meta and forms a real second stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/accu_input_conditioner.sv
// Synchronises and debounces the "next" button and the "in" switch.
// Emits one registered strobe per accepted press, with the in bit captured at that edge.
module accu_input_conditioner
    import accu_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   next_btn,
    input  logic                   in_sw,
    output logic                   next_pulse,
    output logic                   in_bit,
    output logic [PRESS_CNT_W-1:0] press_count,
    output logic [1:0]             cond_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             next_s;
    logic             in_s;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_done;
    logic             accept;

    sync_2ff u_sync_next (.clk(clk), .reset(reset), .d(next_btn), .q(next_s));
    sync_2ff u_sync_in   (.clk(clk), .reset(reset), .d(in_sw),    .q(in_s));

    assign cnt_done = (cnt == CNT_LAST);

    // State register plus the registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= COND_IDLE;
            cnt         <= '0;
            next_pulse  <= 1'b0;
            in_bit      <= 1'b0;
            press_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            next_pulse <= accept;
            if (accept) begin
                in_bit      <= in_s;
                press_count <= press_count + PRESS_CNT_W'(1);
            end
        end
    end

    // NOTE: defaults first so every path assigns state_nxt/cnt_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            COND_IDLE: begin
                if (next_s) begin
                    state_nxt = COND_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            COND_PRESS_WAIT: begin
                if (!next_s) begin
                    state_nxt = COND_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_done) begin
                    state_nxt = COND_HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            COND_HELD: begin
                if (!next_s) begin
                    state_nxt = COND_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            COND_RELEASE_WAIT: begin
                // A release bounce returns to HELD without producing a pulse
                if (next_s) begin
                    state_nxt = COND_HELD;
                    cnt_nxt   = '0;
                end else if (cnt_done) begin
                    state_nxt = COND_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        accept     = (state == COND_PRESS_WAIT) && next_s && cnt_done;
        cond_state = state;
    end

endmodule
